// File: rtl/qtable_pkg.sv
// rtl/qtable_pkg.sv - shared constants and FSM state type for the Q-table enable decoder
package qtable_pkg;

    // Default Q-table depth; the storage array uses the same constant.
    localparam int QT_N_EN = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } qt_state_e;

endpackage

// File: rtl/qtable_en_decoder_onehot_dec.sv
// rtl/qtable_en_decoder_onehot_dec.sv - combinational index to one-hot decoder with range flag
module onehot_dec #(
    parameter int N_EN = 15,
    parameter int AW   = $clog2(N_EN)
) (
    input  logic [AW-1:0]   idx,
    output logic [N_EN-1:0] onehot,
    output logic            in_range
);

    // Exact-match per bit so codes >= N_EN decode to all zeros, never to the top bit.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_EN; i++) begin
            if (int'(idx) == i) begin
                onehot[i] = 1'b1;
            end
        end
    end

    assign in_range = (int'(idx) < N_EN);

endmodule

// File: rtl/qtable_en_decoder.sv
// rtl/qtable_en_decoder.sv - request-driven one-hot enable decoder with sweep mode
module qtable_en_decoder
    import qtable_pkg::*;
#(
    parameter int N_EN = QT_N_EN,
    parameter int AW   = $clog2(N_EN),
    parameter bit HOLD = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    input  logic            req_sweep,
    output logic [N_EN-1:0] en,
    output logic            busy,
    output logic            err,
    output logic            sweep_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N_EN - 1);

    qt_state_e         state;
    logic [AW-1:0]     cnt;
    logic [AW-1:0]     dec_idx;
    logic [N_EN-1:0]   dec_onehot;
    logic              dec_in_range;
    logic              accept;

    assign req_ready = !busy;
    assign accept    = req_valid && req_ready;

    // One decoder serves both paths: in SWEEP it looks one step ahead of cnt.
    always_comb begin
        dec_idx = '0;
        if (state == SWEEP) begin
            dec_idx = cnt + AW'(1);
        end else if (!req_sweep) begin
            dec_idx = req_addr;
        end
    end

    onehot_dec #(
        .N_EN (N_EN),
        .AW   (AW)
    ) u_dec (
        .idx      (dec_idx),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    // cnt holds the index of the enable currently driven during a sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            en         <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            err        <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_sweep) begin
                            state <= SWEEP;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            en    <= dec_onehot;
                        end else begin
                            en  <= dec_in_range ? dec_onehot : '0;
                            err <= !dec_in_range;
                        end
                    end else if (!HOLD) begin
                        en <= '0;
                    end
                end
                SWEEP: begin
                    if (cnt == LAST_IDX) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        cnt        <= '0;
                        en         <= '0;
                        sweep_done <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                        en  <= dec_onehot;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qtable_en_decoder.sv
// tb/tb_qtable_en_decoder.sv - scoreboard bench for qtable_en_decoder in pulse, hold and N_EN=6 builds
module tb_qtable_en_decoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        vld0, vld1, vld2;
    logic        swp0, swp1, swp2;
    logic [3:0]  adr0, adr1;
    logic [2:0]  adr2;
    logic        rdy0, rdy1, rdy2;
    logic [14:0] en0, en1;
    logic [5:0]  en2;
    logic        busy0, busy1, busy2;
    logic        err0, err1, err2;
    logic        done0, done1, done2;

    qtable_en_decoder #(.N_EN(15), .AW(4), .HOLD(1'b0)) u_p15 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld0), .req_ready(rdy0), .req_addr(adr0),
        .req_sweep(swp0), .en(en0), .busy(busy0), .err(err0), .sweep_done(done0));

    qtable_en_decoder #(.N_EN(15), .AW(4), .HOLD(1'b1)) u_h15 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld1), .req_ready(rdy1), .req_addr(adr1),
        .req_sweep(swp1), .en(en1), .busy(busy1), .err(err1), .sweep_done(done1));

    qtable_en_decoder #(.N_EN(6), .AW(3), .HOLD(1'b0)) u_p6 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld2), .req_ready(rdy2), .req_addr(adr2),
        .req_sweep(swp2), .en(en2), .busy(busy2), .err(err2), .sweep_done(done2));

    typedef struct {
        string       name;
        int          id;
        logic [63:0] en;
        logic        err;
        logic        done;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got en=%h err=%b done=%b busy=%b ready=%b, expected en=%h err=%b done=%b busy=%b ready=%b",
                     name, act[67:4], act[3], act[2], act[1], act[0],
                     exp[67:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [67:0] actual(input int id);
        case (id)
            0:       return {49'd0, en0, err0, done0, busy0, rdy0};
            1:       return {49'd0, en1, err1, done1, busy1, rdy1};
            default: return {58'd0, en2, err2, done2, busy2, rdy2};
        endcase
    endfunction

    // Monitor: the DUT presents a new output every cycle; compare just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.name, actual(e.id), {e.en, e.err, e.done, e.busy, !e.busy});
            end
        end
    end

    // One stimulus cycle on DUT id, plus the response expected after the next edge.
    task automatic cyc(input string name, input int id, input logic v, input logic sw,
                       input logic [3:0] addr, input logic [63:0] xen,
                       input logic xerr, input logic xdone, input logic xbusy);
        exp_t e;
        @(negedge clk);
        vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
        swp0 = 1'b0; swp1 = 1'b0; swp2 = 1'b0;
        case (id)
            0:       begin vld0 = v; swp0 = sw; adr0 = addr; end
            1:       begin vld1 = v; swp1 = sw; adr1 = addr; end
            default: begin vld2 = v; swp2 = sw; adr2 = addr[2:0]; end
        endcase
        e.name = name; e.id = id; e.en = xen; e.err = xerr; e.done = xdone; e.busy = xbusy;
        q.push_back(e);
    endtask

    initial begin
        vld0 = 0; vld1 = 0; vld2 = 0; swp0 = 0; swp1 = 0; swp2 = 0;
        adr0 = 0; adr1 = 0; adr2 = 0;
        rst_n = 1'b0;
        #2;
        check("reset_p15", actual(0), 68'h1);
        check("reset_h15", actual(1), 68'h1);
        check("reset_p6",  actual(2), 68'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Pulse, N_EN=15: single, out-of-range, top index, back-to-back
        cyc("p_addr5",   0, 1, 0, 4'd5,  64'h0020, 0, 0, 0);
        cyc("p_idle",    0, 0, 0, 4'd0,  64'h0,    0, 0, 0);
        cyc("p_idle2",   0, 0, 0, 4'd0,  64'h0,    0, 0, 0);
        cyc("p_addr15",  0, 1, 0, 4'd15, 64'h0,    1, 0, 0);
        cyc("p_addr14",  0, 1, 0, 4'd14, 64'h4000, 0, 0, 0);
        cyc("p_b2b1",    0, 1, 0, 4'd1,  64'h0002, 0, 0, 0);
        cyc("p_b2b2",    0, 1, 0, 4'd2,  64'h0004, 0, 0, 0);
        cyc("p_b2b3",    0, 1, 0, 4'd3,  64'h0008, 0, 0, 0);
        cyc("p_idle3",   0, 0, 0, 4'd0,  64'h0,    0, 0, 0);

        // Sweep with a single request held valid throughout
        cyc("sw_acc", 0, 1, 1, 4'd0, 64'h1, 0, 0, 1);
        for (int k = 1; k < 15; k++) cyc("sw_walk", 0, 1, 0, 4'd5, 64'h1 << k, 0, 0, 1);
        cyc("sw_done",  0, 1, 0, 4'd5, 64'h0,    0, 1, 0);
        cyc("sw_held",  0, 1, 0, 4'd5, 64'h0020, 0, 0, 0);
        cyc("sw_after", 0, 0, 0, 4'd0, 64'h0,    0, 0, 0);

        // Hold, N_EN=15
        cyc("h_addr3", 1, 1, 0, 4'd3, 64'h0008, 0, 0, 0);
        for (int k = 0; k < 10; k++) cyc("h_keep3", 1, 0, 0, 4'd0, 64'h0008, 0, 0, 0);
        cyc("h_addr9",  1, 1, 0, 4'd9,  64'h0200, 0, 0, 0);
        cyc("h_keep9",  1, 0, 0, 4'd0,  64'h0200, 0, 0, 0);
        cyc("h_addr15", 1, 1, 0, 4'd15, 64'h0,    1, 0, 0);
        cyc("h_keep0",  1, 0, 0, 4'd0,  64'h0,    0, 0, 0);
        cyc("h_addr7",  1, 1, 0, 4'd7,  64'h0080, 0, 0, 0);
        cyc("h_sw_acc", 1, 1, 1, 4'd0,  64'h1,    0, 0, 1);
        for (int k = 1; k < 15; k++) cyc("h_sw_walk", 1, 0, 0, 4'd0, 64'h1 << k, 0, 0, 1);
        cyc("h_sw_done", 1, 0, 0, 4'd0, 64'h0, 0, 1, 0);
        cyc("h_sw_zero", 1, 0, 0, 4'd0, 64'h0, 0, 0, 0);

        // N_EN=6, AW=3: two unused codes and a short sweep
        cyc("s6_addr6", 2, 1, 0, 4'd6, 64'h0,  1, 0, 0);
        cyc("s6_addr7", 2, 1, 0, 4'd7, 64'h0,  1, 0, 0);
        cyc("s6_addr5", 2, 1, 0, 4'd5, 64'h20, 0, 0, 0);
        cyc("s6_sw_acc", 2, 1, 1, 4'd0, 64'h1, 0, 0, 1);
        for (int k = 1; k < 6; k++) cyc("s6_sw_walk", 2, 0, 0, 4'd0, 64'h1 << k, 0, 0, 1);
        cyc("s6_sw_done", 2, 0, 0, 4'd0, 64'h0, 0, 1, 0);
        cyc("s6_idle",    2, 0, 0, 4'd0, 64'h0, 0, 0, 0);

        // Asynchronous reset during sweep cycle 7
        cyc("r_sw_acc", 0, 1, 1, 4'd0, 64'h1, 0, 0, 1);
        for (int k = 1; k < 7; k++) cyc("r_sw_walk", 0, 0, 0, 4'd0, 64'h1 << k, 0, 0, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_async", actual(0), 68'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("r_hold", actual(0), 68'h1);
        end
        rst_n = 1'b1;
        cyc("r_no_done", 0, 0, 0, 4'd0, 64'h0,    0, 0, 0);
        cyc("r_addr0",   0, 1, 0, 4'd0, 64'h0001, 0, 0, 0);
        cyc("r_idle",    0, 0, 0, 4'd0, 64'h0,    0, 0, 0);

        @(negedge clk);
        vld0 = 0; vld1 = 0; vld2 = 0;
        repeat (4) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected responses left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
